// File: rtl/rv32i_pkg.sv
// Shared RV32I core types: data width, canonical NOP, fetch bundle.
// fetch_entry_t carries one fetched word together with its PC.
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/clear and occupancy count.
// Ports: clk, reset, push_i/push_data_i, pop_i, clear_i, head_o, count_o.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             empty, full;
   logic             do_push, do_pop;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));

   // A pop frees a slot, so push into a full FIFO is fine when popping too.
   assign do_pop  = pop_i && !empty;
   assign do_push = push_i && (!full || do_pop);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + AW'(1);
         if (do_pop)  rd_d = rd_q + AW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear_i) mem_q[wr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues imem requests, buffers words for decode.
// Ports: clk/reset, imem_req_*/imem_rsp_* to memory, redirect_* from EX, id_* to decode.
module instr_fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 2;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   pend_cnt, buf_cnt;
   logic [CW-1:0]   inflight;
   logic [XLEN-1:0] pend_head;
   fetch_entry_t    buf_head, buf_push;
   logic            credit_ok;
   logic            accept, rsp_drop, rsp_keep, id_pop;

   // Every slot ever granted (in flight, to be dropped, or buffered) counts.
   assign credit_ok = (SW'(pend_cnt) + SW'(drop_q) + SW'(buf_cnt))
                      < SW'(FIFO_DEPTH);

   assign imem_req_valid = !reset && !redirect_valid && credit_ok;
   assign imem_req_addr  = fetch_pc_q;
   assign accept         = imem_req_valid && imem_req_ready;

   assign rsp_drop = imem_rsp_valid && (drop_q != '0);
   assign rsp_keep = imem_rsp_valid && (drop_q == '0)
                     && (pend_cnt != '0) && !redirect_valid;

   assign id_valid = (buf_cnt != '0);
   assign id_pop   = id_valid && id_ready && !redirect_valid;
   assign id_inst  = id_valid ? buf_head.inst : '0;
   assign id_pc    = id_valid ? buf_head.pc   : '0;

   assign buf_push.pc   = pend_head;
   assign buf_push.inst = imem_rsp_data;

   // On redirect all still-pending words become stale; a response
   // arriving in that same cycle retires one of them immediately.
   assign inflight = drop_q + pend_cnt;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~XLEN'(3);
         if (imem_rsp_valid && (inflight != '0))
            drop_d = inflight - CW'(1);
         else
            drop_d = inflight;
      end else begin
         if (accept)   fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (rsp_drop) drop_d     = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (XLEN)
   ) u_pend_q (
      .clk         (clk),
      .reset       (reset),
      .push_i      (accept),
      .push_data_i (fetch_pc_q),
      .pop_i       (rsp_keep),
      .clear_i     (redirect_valid),
      .head_o      (pend_head),
      .count_o     (pend_cnt)
   );

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_out_buf (
      .clk         (clk),
      .reset       (reset),
      .push_i      (rsp_keep),
      .push_data_i (buf_push),
      .pop_i       (id_pop),
      .clear_i     (redirect_valid),
      .head_o      (buf_head),
      .count_o     (buf_cnt)
   );

   a_rsp_orphan: assert property (
      @(posedge clk) disable iff (reset)
      imem_rsp_valid |-> ((pend_cnt != '0) || (drop_q != '0))
   );

endmodule
